// File: rtl/data_memory_unit_if.sv
// data_memory_unit_if: memory-stage bus between the EX/MEM register (master) and data_memory_unit (slave).
interface data_memory_unit_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] address;
   logic [WIDTH-1:0] w_data;
   logic             write_en;
   logic [WIDTH-1:0] r_data;

   modport master (output address, output w_data, output write_en, input  r_data);
   modport slave  (input  address, input  w_data, input  write_en, output r_data);
endinterface

// File: rtl/data_memory_unit.sv
// data_memory_unit: word-addressed data RAM plus GPIO and optional timer MMIO; read data is combinational.
// Timer is built only when DMU_TIMER_EN is defined; otherwise its offsets read 0 and irq_o is 0.
module data_memory_unit #(
   parameter int               WIDTH      = 32,
   parameter int               DEPTH      = 256,
   parameter logic [WIDTH-1:0] MMIO_BASE  = 32'h0000_1000,
   parameter int               GPIO_WIDTH = 8
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   data_memory_unit_if.slave     bus,
   input  logic [GPIO_WIDTH-1:0] gpio_in_i,
   output logic [GPIO_WIDTH-1:0] gpio_out_o,
   output logic                  irq_o
);
   localparam int         AW           = $clog2(DEPTH);
   localparam logic [2:0] SEL_GPIO_OUT = 3'd0;
   localparam logic [2:0] SEL_GPIO_IN  = 3'd1;
   localparam logic [2:0] SEL_T_COUNT  = 3'd2;
   localparam logic [2:0] SEL_T_CMP    = 3'd3;
   localparam logic [2:0] SEL_T_CTRL   = 3'd4;
   localparam logic [2:0] SEL_T_STATUS = 3'd5;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [GPIO_WIDTH-1:0] gpio_out_q;
   logic [GPIO_WIDTH-1:0] gpio_out_d;
   logic [GPIO_WIDTH-1:0] sync1_q;
   logic [GPIO_WIDTH-1:0] sync2_q;
   logic                  is_mmio_s;
   logic                  wr_mmio_s;
   logic                  wr_ram_s;
   logic [WIDTH-1:0]      offset_s;
   logic [2:0]            sel_s;
   logic [AW-1:0]         ram_idx_s;
   logic [WIDTH-1:0]      mmio_rdata_s;
   logic                  unused_s;

   assign is_mmio_s = (bus.address >= MMIO_BASE);
   assign offset_s  = bus.address - MMIO_BASE;
   assign sel_s     = offset_s[4:2];
   assign unused_s  = ^{offset_s[WIDTH-1:5], offset_s[1:0]};
   assign ram_idx_s = bus.address[AW+1:2];
   assign wr_mmio_s = bus.write_en & is_mmio_s;
   // A reset cycle also suppresses the RAM write so nothing lands while reset is held.
   assign wr_ram_s  = bus.write_en & ~is_mmio_s & reset_i;

   // RAM array: not reset, written at the edge.
   always_ff @(posedge clock_i) begin
      if (wr_ram_s) begin
         mem_q[ram_idx_s] <= bus.w_data;
      end
   end

   // GPIO output register next state.
   always_comb begin
      gpio_out_d = gpio_out_q;
      if (wr_mmio_s && (sel_s == SEL_GPIO_OUT)) begin
         gpio_out_d = bus.w_data[GPIO_WIDTH-1:0];
      end else begin
         gpio_out_d = gpio_out_q;
      end
   end

   // GPIO output register and two-flop input synchronizer.
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         gpio_out_q <= {GPIO_WIDTH{1'b0}};
         sync1_q    <= {GPIO_WIDTH{1'b0}};
         sync2_q    <= {GPIO_WIDTH{1'b0}};
      end else begin
         gpio_out_q <= gpio_out_d;
         sync1_q    <= gpio_in_i;
         sync2_q    <= sync1_q;
      end
   end

   assign gpio_out_o = gpio_out_q;

`ifdef DMU_TIMER_EN
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] cmp_q;
   logic [WIDTH-1:0] cmp_d;
   logic [2:0]       ctrl_q;
   logic [2:0]       ctrl_d;
   logic             flag_q;
   logic             flag_d;
   logic             match_s;

   assign match_s = ctrl_q[0] && (count_q == cmp_q);

   // Timer next state: software count write beats auto-clear and increment; a match beats W1C.
   always_comb begin
      count_d = count_q;
      cmp_d   = cmp_q;
      ctrl_d  = ctrl_q;
      flag_d  = flag_q;
      if (wr_mmio_s && (sel_s == SEL_T_COUNT)) begin
         count_d = bus.w_data;
      end else if (match_s && ctrl_q[1]) begin
         count_d = {WIDTH{1'b0}};
      end else if (ctrl_q[0]) begin
         count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
      if (wr_mmio_s && (sel_s == SEL_T_CMP)) begin
         cmp_d = bus.w_data;
      end else begin
         cmp_d = cmp_q;
      end
      if (wr_mmio_s && (sel_s == SEL_T_CTRL)) begin
         ctrl_d = bus.w_data[2:0];
      end else begin
         ctrl_d = ctrl_q;
      end
      if (match_s) begin
         flag_d = 1'b1;
      end else if (wr_mmio_s && (sel_s == SEL_T_STATUS) && bus.w_data[0]) begin
         flag_d = 1'b0;
      end else begin
         flag_d = flag_q;
      end
   end

   // Timer registers.
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         count_q <= {WIDTH{1'b0}};
         cmp_q   <= {WIDTH{1'b0}};
         ctrl_q  <= 3'b000;
         flag_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         cmp_q   <= cmp_d;
         ctrl_q  <= ctrl_d;
         flag_q  <= flag_d;
      end
   end

   assign irq_o = flag_q & ctrl_q[2];
`else
   assign irq_o = 1'b0;
`endif

   // MMIO read mux; unmapped offsets read zero.
   always_comb begin
      mmio_rdata_s = {WIDTH{1'b0}};
      case (sel_s)
         SEL_GPIO_OUT: mmio_rdata_s = {{(WIDTH-GPIO_WIDTH){1'b0}}, gpio_out_q};
         SEL_GPIO_IN:  mmio_rdata_s = {{(WIDTH-GPIO_WIDTH){1'b0}}, sync2_q};
`ifdef DMU_TIMER_EN
         SEL_T_COUNT:  mmio_rdata_s = count_q;
         SEL_T_CMP:    mmio_rdata_s = cmp_q;
         SEL_T_CTRL:   mmio_rdata_s = {{(WIDTH-3){1'b0}}, ctrl_q};
         SEL_T_STATUS: mmio_rdata_s = {{(WIDTH-1){1'b0}}, flag_q};
`endif
         default:      mmio_rdata_s = {WIDTH{1'b0}};
      endcase
   end

   assign bus.r_data = is_mmio_s ? mmio_rdata_s : mem_q[ram_idx_s];
endmodule
